// File: rtl/verdict_uart_tx.sv
// verdict_uart_tx: turns accept/reject verdict edges into "ACK\n" / "NAK\n"
// on a UART line (8N1, LSB first, CLKS_PER_BIT clocks per bit).
// A one-deep pending slot holds a verdict that arrives mid-message; a newer
// verdict overwrites it and pulses overflow.
// Optional: define VERDICT_TX_PARITY_EN to insert an even parity bit
// between data bit 7 and the stop bit.
module verdict_uart_tx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst_n,
  input  logic accept,
  input  logic reject,
  output logic tx,
  output logic busy,
  output logic overflow
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef VERDICT_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state, state_nxt;
  logic            acc_q, rej_q, armed;
  logic            acc_rise, rej_rise, ev, ev_nak;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [1:0]      byte_idx;
  logic            msg_nak;
  logic            pend_vld, pend_nak;
  logic            baud_end, last_stop, launch, launch_nak;
  logic [7:0]      cur_byte;

  // armed masks the first cycle after reset so a level already high is not an edge
  assign acc_rise   = armed & accept & ~acc_q;
  assign rej_rise   = armed & reject & ~rej_q;
  assign ev         = acc_rise | rej_rise;
  assign ev_nak     = rej_rise;           // reject wins a same-cycle tie
  assign baud_end   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign last_stop  = (state == STOP) && baud_end && (byte_idx == 2'd3);
  // a message starts from idle, or straight out of the final stop bit
  assign launch     = ((state == IDLE) || last_stop) && (ev || pend_vld);
  // the pending verdict is older than a same-cycle event, so it goes first
  assign launch_nak = pend_vld ? pend_nak : ev_nak;
  assign busy       = (state != IDLE);

  // message byte lookup
  always_comb begin
    cur_byte = 8'h0A;
    case ({msg_nak, byte_idx})
      3'b0_00: cur_byte = 8'h41;
      3'b0_01: cur_byte = 8'h43;
      3'b0_10: cur_byte = 8'h4B;
      3'b1_00: cur_byte = 8'h4E;
      3'b1_01: cur_byte = 8'h41;
      3'b1_10: cur_byte = 8'h4B;
      default: cur_byte = 8'h0A;
    endcase
  end

  // input edge registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
      rej_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      acc_q <= accept;
      rej_q <= reject;
      armed <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state and serial line decode
  always_comb begin
    state_nxt = state;
    tx        = 1'b1;
    case (state)
      IDLE:  if (launch) state_nxt = START;
      START: begin
        tx = 1'b0;
        if (baud_end) state_nxt = DATA;
      end
      DATA: begin
        tx = cur_byte[bit_cnt];
        if (baud_end && bit_cnt == 3'd7) begin
`ifdef VERDICT_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef VERDICT_TX_PARITY_EN
      PARITY: begin
        tx = ^cur_byte;
        if (baud_end) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (baud_end) begin
          if (byte_idx != 2'd3) state_nxt = START;
          else if (launch)      state_nxt = START;
          else                  state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // baud, bit and byte counters; message select latched at launch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      msg_nak  <= 1'b0;
    end else if (launch) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      msg_nak  <= launch_nak;
    end else if (state != IDLE) begin
      baud_cnt <= baud_end ? '0 : baud_cnt + CW'(1);
      if (baud_end && state == DATA) bit_cnt  <= bit_cnt + 3'd1;
      if (baud_end && state == STOP) byte_idx <= byte_idx + 2'd1;
    end
  end

  // one-deep pending slot and overflow pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_nak <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (launch) begin
        // slot drains into the new message; a same-cycle event refills it
        if (pend_vld) begin
          pend_vld <= ev;
          pend_nak <= ev_nak;
        end
      end else if (ev && busy) begin
        overflow <= pend_vld;
        pend_vld <= 1'b1;
        pend_nak <= ev_nak;
      end
    end
  end

endmodule

// File: tb/tb_verdict_uart_tx.sv
// Bench for verdict_uart_tx: schedules of accept/reject levels are applied
// cycle by cycle, the tx/busy/overflow trace is recorded, and the trace is
// compared with a message-level model of the verdict queueing rules.
module tb_verdict_uart_tx;
  localparam int CPB  = 4;
`ifdef VERDICT_TX_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam int BT = BITS * CPB;   // clocks per byte
  localparam int ML = 4 * BT;       // clocks per message
  localparam int N  = 1100;

  logic clk = 1'b0, rst_n = 1'b0, accept = 1'b0, reject = 1'b0;
  logic tx, busy, overflow;

  verdict_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .accept(accept), .reject(reject),
    .tx(tx), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_run = 0, n_fail = 0;

  bit   acc_s[N], rej_s[N];
  logic tx_tr[N], busy_tr[N], ovf_tr[N];
  int   l_p[$];
  bit   l_nak[$];
  int   ovf_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] msg_byte(input bit nak, input int b);
    case (b)
      0:       return nak ? 8'h4E : 8'h41;
      1:       return nak ? 8'h41 : 8'h43;
      2:       return 8'h4B;
      default: return 8'h0A;
    endcase
  endfunction

  // expected line level at offset off into a message
  function automatic logic exp_bit(input bit nak, input int off);
    logic [7:0] d;
    int k;
    d = msg_byte(nak, off / BT);
    k = (off % BT) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (BITS == 11 && k == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic clr_sched();
    for (int t = 0; t < N; t++) begin acc_s[t] = 0; rej_s[t] = 0; end
  endtask

  // kind: 0 accept, 1 reject, 2 both
  task automatic pulse(input int kind, input int s, input int w);
    for (int t = s; t < s + w && t < N; t++) begin
      if (kind != 1) acc_s[t] = 1;
      if (kind != 0) rej_s[t] = 1;
    end
  endtask

  // starts from just after a rising edge (+1); leaves the same alignment
  task automatic run_sched();
    for (int t = 0; t < N; t++) begin
      accept = acc_s[t];
      reject = rej_s[t];
      @(posedge clk); #1;
      tx_tr[t] = tx; busy_tr[t] = busy; ovf_tr[t] = overflow;
    end
    accept = 0; reject = 0;
  endtask

  // message-level model: line free at cycle e; pending slot holds one verdict
  task automatic model();
    int e; bit pend, pnak, pa, pr, ra, rr;
    l_p.delete(); l_nak.delete(); ovf_q.delete();
    e = 0; pend = 0; pnak = 0; pa = 0; pr = 0;
    for (int t = 0; t < N; t++) begin
      ra = acc_s[t] && !pa; rr = rej_s[t] && !pr;
      pa = acc_s[t]; pr = rej_s[t];
      if (ra || rr) begin
        if (pend && e <= t) begin
          l_p.push_back(e); l_nak.push_back(pnak); e += ML; pend = 0;
        end
        if (t >= e) begin
          l_p.push_back(t); l_nak.push_back(rr); e = t + ML;
        end else if (pend) begin
          ovf_q.push_back(t); pnak = rr;
        end else begin
          pend = 1; pnak = rr;
        end
      end
    end
    if (pend) begin l_p.push_back(e); l_nak.push_back(pnak); end
  endtask

  task automatic compare(input string name);
    int tx_e, bs_e, ov_e, bs_n, bs_x, ov_n;
    tx_e = 0; bs_e = 0; ov_e = 0; bs_n = 0; bs_x = 0; ov_n = 0;
    for (int t = 0; t < N; t++) begin
      logic eb, et, eo;
      eb = 0; et = 1; eo = 0;
      foreach (l_p[i])
        if (t >= l_p[i] && t < l_p[i] + ML) begin eb = 1; et = exp_bit(l_nak[i], t - l_p[i]); end
      foreach (ovf_q[i]) if (ovf_q[i] == t) eo = 1;
      if (tx_tr[t] !== et)   tx_e++;
      if (busy_tr[t] !== eb) bs_e++;
      if (ovf_tr[t] !== eo)  ov_e++;
      if (busy_tr[t] === 1'b1) bs_n++;
      if (eb) bs_x++;
      if (ovf_tr[t] === 1'b1) ov_n++;
    end
    chk({name, "/tx_err"}, tx_e, 0);
    chk({name, "/busy_err"}, bs_e, 0);
    chk({name, "/ovf_err"}, ov_e, 0);
    chk({name, "/busy_cycles"}, bs_n, bs_x);
    chk({name, "/ovf_count"}, ov_n, ovf_q.size());
  endtask

  function automatic logic [7:0] decode(input int s);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = tx_tr[s + (i + 1) * CPB + CPB / 2];
    return d;
  endfunction

  initial begin
    int cnt_tx, cnt_bs;
    logic [7:0] ack_b [4];
    ack_b[0] = 8'h41; ack_b[1] = 8'h43; ack_b[2] = 8'h4B; ack_b[3] = 8'h0A;

    // reset state
    repeat (3) @(posedge clk); #1;
    chk("rst/tx", tx, 1); chk("rst/busy", busy, 0); chk("rst/ovf", overflow, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // accept edge in idle, with byte-level decode and absolute timing
    clr_sched(); pulse(0, 5, 10); run_sched(); model(); compare("accept");
    chk("accept/pre_start", tx_tr[4], 1);
    chk("accept/start_lat", tx_tr[5], 0);
    chk("accept/busy_len", l_p.size() * ML, 160 * BITS / 10);
    for (int b = 0; b < 4; b++) chk($sformatf("accept/byte%0d", b), decode(5 + b * BT), ack_b[b]);

    clr_sched(); pulse(1, 5, 4); run_sched(); model(); compare("reject");
    chk("reject/byte0", decode(5), 8'h4E);

    clr_sched(); pulse(2, 5, 3); run_sched(); model(); compare("both");
    chk("both/byte0", decode(5), 8'h4E);

    // in flight ACK, pending NAK at +20, overwritten by ACK at +30
    clr_sched(); pulse(0, 5, 5); pulse(1, 25, 15); pulse(0, 35, 15);
    run_sched(); model(); compare("overwrite");
    chk("overwrite/ovf_at_30", ovf_tr[35], 1);
    chk("overwrite/2nd_msg", decode(5 + ML), 8'h41);

    for (int r = 0; r < 8; r++) begin
      clr_sched();
      for (int p = 0; p < int'($urandom_range(5, 1)); p++)
        pulse($urandom_range(2, 0), $urandom_range(600, 2), $urandom_range(20, 1));
      run_sched(); model(); compare($sformatf("rand%0d", r));
    end

    // reset 50 cycles into a message with accept held high through release
    for (int t = 0; t < 56; t++) begin
      accept = (t >= 5);
      @(posedge clk); #1;
    end
    chk("rstmid/busy_before", busy, 1);
    rst_n = 0; #1;
    chk("rstmid/tx", tx, 1); chk("rstmid/busy", busy, 0); chk("rstmid/ovf", overflow, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1;
    cnt_tx = 0; cnt_bs = 0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) cnt_tx++;
      if (busy !== 1'b0) cnt_bs++;
    end
    chk("rstmid/no_tx", cnt_tx, 0); chk("rstmid/no_busy", cnt_bs, 0);
    accept = 0; @(posedge clk); #1;
    accept = 1; @(posedge clk); #1;
    chk("rstmid/resume_start", tx, 0); chk("rstmid/resume_busy", busy, 1);
    repeat (ML + 4) @(posedge clk); #1;
    chk("rstmid/resume_done", busy, 0);
    accept = 0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
